// File: rtl/fifo_read_stream.sv
// Read-side stream adapter for async_fifo: turns the one-cycle-latency FIFO read port into
// valid/ready with a 3-entry prefetch buffer. Optional statistics via FIFO_READ_STREAM_STATS_EN.
module fifo_read_stream #(
   parameter int BITS = 32
) (
   input  logic            read_clk,
   input  logic            read_rst_n,
   output logic            p_read_en,
   input  logic [BITS-1:0] p_read_data,
   input  logic            p_read_empty,
   output logic            m_valid,
   output logic [BITS-1:0] m_data,
   input  logic            m_ready,
`ifdef FIFO_READ_STREAM_STATS_EN
   output logic [31:0]     stat_words,
   output logic [31:0]     stat_stalls,
`endif
   output logic [1:0]      m_level
);

   logic [BITS-1:0] mem [3];
   logic [1:0]      head;
   logic [1:0]      tail;
   logic [1:0]      count;
   logic [1:0]      count_next;
   logic            inflight;
   logic [2:0]      fill;
   logic            push;
   logic            pop;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Issue only when a slot is reserved for every word already requested.
   always_comb begin
      fill       = {1'b0, count} + {2'b00, inflight};
      p_read_en  = read_rst_n & ~p_read_empty & (fill < 3'd3);
      push       = inflight;
      pop        = (count != 2'd0) & m_ready;
      count_next = count + {1'b0, push} - {1'b0, pop};
      m_valid    = (count != 2'd0);
      m_level    = count;
      case (head)
         2'd0:    m_data = mem[0];
         2'd1:    m_data = mem[1];
         2'd2:    m_data = mem[2];
         default: m_data = '0;
      endcase
   end

   always_ff @(posedge read_clk) begin
      if (!read_rst_n) begin
         count    <= 2'd0;
         head     <= 2'd0;
         tail     <= 2'd0;
         inflight <= 1'b0;
         for (int i = 0; i < 3; i++) mem[i] <= '0;
      end else begin
         inflight <= p_read_en;
         count    <= count_next;
         if (push) begin
            for (int i = 0; i < 3; i++)
               if (tail == 2'(i)) mem[i] <= p_read_data;
            tail <= ptr_inc(tail);
         end
         if (pop) head <= ptr_inc(head);
      end
   end

`ifdef FIFO_READ_STREAM_STATS_EN
   always_ff @(posedge read_clk) begin
      if (!read_rst_n) begin
         stat_words  <= 32'd0;
         stat_stalls <= 32'd0;
      end else begin
         if (pop) stat_words <= stat_words + 32'd1;
         if (m_valid & ~m_ready) stat_stalls <= stat_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_read_stream.sv
// Self-checking bench for fifo_read_stream: behavioural FIFO read port plus an in-order scoreboard.
module tb_fifo_read_stream;
   localparam int BITS = 32;

   logic            read_clk;
   logic            read_rst_n;
   logic            p_read_en;
   logic [BITS-1:0] p_read_data;
   logic            p_read_empty;
   logic            m_valid;
   logic [BITS-1:0] m_data;
   logic            m_ready;
   logic [1:0]      m_level;
`ifdef FIFO_READ_STREAM_STATS_EN
   logic [31:0]     stat_words;
   logic [31:0]     stat_stalls;
`endif

   int checks;
   int failures;
   logic [BITS-1:0] fifo_q [$];
   logic [BITS-1:0] exp_q  [$];

   fifo_read_stream #(.BITS(BITS)) dut (
      .read_clk     (read_clk),
      .read_rst_n   (read_rst_n),
      .p_read_en    (p_read_en),
      .p_read_data  (p_read_data),
      .p_read_empty (p_read_empty),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_ready      (m_ready),
`ifdef FIFO_READ_STREAM_STATS_EN
      .stat_words   (stat_words),
      .stat_stalls  (stat_stalls),
`endif
      .m_level      (m_level)
   );

   initial begin
      read_clk = 1'b0;
      forever #5 read_clk = ~read_clk;
   end

   // One read-clock cycle: sample the cycle's handshake, cross the edge, then model the FIFO port.
   task automatic tick(output bit rd, output bit v, output bit acc, output logic [BITS-1:0] d);
      #1;
      rd  = p_read_en;
      v   = m_valid;
      acc = m_valid && m_ready;
      d   = m_data;
      @(posedge read_clk);
      #1;
      if (rd && fifo_q.size() > 0) p_read_data = fifo_q.pop_front();
      p_read_empty = (fifo_q.size() == 0);
   endtask

   task automatic load(input logic [BITS-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         fifo_q.push_back(base + BITS'(i));
         exp_q.push_back(base + BITS'(i));
      end
      p_read_empty = (fifo_q.size() == 0);
   endtask

   task automatic test_reset();
      read_rst_n   = 1'b0;
      p_read_empty = 1'b0;
      p_read_data  = 32'hA5A5_A5A5;
      m_ready      = 1'b0;
      repeat (4) @(posedge read_clk);
      #1;
      checks++; if (p_read_en !== 1'b0) begin failures++; $display("FAIL reset_p_read_en got=%b exp=0", p_read_en); end
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
      checks++; if (m_level !== 2'd0) begin failures++; $display("FAIL reset_m_level got=%0d exp=0", m_level); end
      checks++; if (m_data !== 32'h0) begin failures++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
      p_read_empty = 1'b1;
      p_read_data  = '0;
      read_rst_n   = 1'b1;
      repeat (2) @(posedge read_clk);
      #1;
   endtask

   task automatic test_streaming();
      bit rd, v, acc;
      logic [BITS-1:0] d, e;
      int first_rd = -1, first_v = -1, last_acc = -1, gaps = 0, n_acc = 0;
      m_ready = 1'b1;
      load(32'h0, 16);
      for (int cyc = 0; cyc < 40; cyc++) begin
         tick(rd, v, acc, d);
         if (rd && first_rd < 0) first_rd = cyc;
         if (acc) begin
            if (first_v < 0) first_v = cyc;
            if (last_acc >= 0 && cyc != last_acc + 1) gaps++;
            last_acc = cyc;
            n_acc++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
            checks++; if (d !== e) begin failures++; $display("FAIL stream_data got=%h exp=%h", d, e); end
         end
      end
      checks++; if (first_v - first_rd != 2) begin failures++; $display("FAIL stream_latency got=%0d exp=2", first_v - first_rd); end
      checks++; if (n_acc != 16) begin failures++; $display("FAIL stream_count got=%0d exp=16", n_acc); end
      checks++; if (gaps != 0) begin failures++; $display("FAIL stream_gaps got=%0d exp=0", gaps); end
   endtask

   task automatic test_backpressure();
      bit rd, v, acc;
      logic [BITS-1:0] d, e;
      int n_rd = 0, n_acc = 0, bad_hold = 0;
      m_ready = 1'b0;
      load(32'h100, 8);
      for (int cyc = 0; cyc < 10; cyc++) begin
         tick(rd, v, acc, d);
         if (rd) n_rd++;
         if (v && d !== 32'h100) bad_hold++;
      end
      checks++; if (n_rd != 3) begin failures++; $display("FAIL bp_reads got=%0d exp=3", n_rd); end
      checks++; if (m_level !== 2'd3) begin failures++; $display("FAIL bp_level got=%0d exp=3", m_level); end
      checks++; if (bad_hold != 0) begin failures++; $display("FAIL bp_hold got=%0d exp=0", bad_hold); end
      m_ready = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         tick(rd, v, acc, d);
         if (acc) begin
            n_acc++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
            checks++; if (d !== e) begin failures++; $display("FAIL bp_data got=%h exp=%h", d, e); end
         end
      end
      checks++; if (n_acc != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", n_acc); end
   endtask

   task automatic test_push_pop();
      bit rd, v, acc;
      logic [BITS-1:0] d, e;
      int n_acc = 0, over = 0;
      m_ready = 1'b1;
      load(32'h1000, 20);
      for (int cyc = 0; cyc < 80; cyc++) begin
         tick(rd, v, acc, d);
         if (m_level > 2'd3 || $isunknown(m_level)) over++;
         if (acc) begin
            n_acc++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
            checks++; if (d !== e) begin failures++; $display("FAIL pp_data got=%h exp=%h", d, e); end
         end
         m_ready = ~m_ready;
      end
      checks++; if (over != 0) begin failures++; $display("FAIL pp_level got=%0d exp=0", over); end
      checks++; if (n_acc != 20) begin failures++; $display("FAIL pp_count got=%0d exp=20", n_acc); end
   endtask

   task automatic test_empty_edge();
      bit rd, v, acc;
      logic [BITS-1:0] d;
      int n_rd = 0, n_acc = 0;
      m_ready = 1'b1;
      fifo_q.push_back(32'hDEAD_BEEF);
      exp_q.push_back(32'hDEAD_BEEF);
      p_read_empty = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         tick(rd, v, acc, d);
         if (rd) n_rd++;
         if (acc) begin
            n_acc++;
            checks++; if (d !== exp_q[0]) begin failures++; $display("FAIL empty_data got=%h exp=%h", d, exp_q[0]); end
            void'(exp_q.pop_front());
         end
      end
      #1;
      checks++; if (n_rd != 1) begin failures++; $display("FAIL empty_reads got=%0d exp=1", n_rd); end
      checks++; if (n_acc != 1) begin failures++; $display("FAIL empty_beats got=%0d exp=1", n_acc); end
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL empty_valid got=%b exp=0", m_valid); end
      checks++; if (p_read_en !== 1'b0) begin failures++; $display("FAIL empty_rd_en got=%b exp=0", p_read_en); end
   endtask

   task automatic test_mid_reset();
      bit rd, v, acc, last_rd;
      logic [BITS-1:0] d;
      int seen = 0, late = 0;
      m_ready = 1'b0;
      load(32'h200, 8);
      last_rd = 1'b0;
      for (int cyc = 0; cyc < 10 && seen == 0; cyc++) begin
         tick(rd, v, acc, d);
         last_rd = rd;
         if (m_level == 2'd2) seen = 1;
      end
      checks++; if (seen != 1 || last_rd != 1'b1) begin failures++; $display("FAIL mrst_setup got=%0d/%b exp=1/1", seen, last_rd); end
      read_rst_n = 1'b0;
      tick(rd, v, acc, d);
      fifo_q.delete();
      exp_q.delete();
      checks++; if (m_level !== 2'd0) begin failures++; $display("FAIL mrst_level got=%0d exp=0", m_level); end
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL mrst_valid got=%b exp=0", m_valid); end
`ifdef FIFO_READ_STREAM_STATS_EN
      checks++; if (stat_words !== 32'd0) begin failures++; $display("FAIL mrst_stat_words got=%0d exp=0", stat_words); end
      checks++; if (stat_stalls !== 32'd0) begin failures++; $display("FAIL mrst_stat_stalls got=%0d exp=0", stat_stalls); end
`endif
      p_read_empty = 1'b1;
      read_rst_n   = 1'b1;
      for (int cyc = 0; cyc < 5; cyc++) begin
         tick(rd, v, acc, d);
         if (v || rd) late++;
      end
      checks++; if (late != 0) begin failures++; $display("FAIL mrst_late got=%0d exp=0", late); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      m_ready  = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_push_pop();
      test_empty_edge();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_read_stream.md
# fifo_read_stream

Read-side adapter placed directly downstream of `async_fifo` in the read clock domain. Converts the FIFO's registered read port (`p_read_en` / `p_read_empty` / `p_read_data`, one-cycle read latency) into a valid/ready stream with a 3-entry prefetch buffer. Sustains one word per cycle with no bubbles while the FIFO stays non-empty and the sink stays ready. Word order is preserved exactly.

## Interface
- `BITS`, 32, data width; equals the `async_fifo` `BITS`.
- `read_clk`  in  1  read-domain clock, shared with the `async_fifo` read side.
- `read_rst_n`  in  1  synchronous active-low reset; the same net as the FIFO's read reset.
- `p_read_en`  out  1  read request to the FIFO.
- `p_read_data`  in  BITS  FIFO read data; valid in the cycle after an accepted read.
- `p_read_empty`  in  1  FIFO empty flag.
- `m_valid`  out  1  output word available.
- `m_data`  out  BITS  output word; equals the buffer head.
- `m_ready`  in  1  sink accepts the word this cycle.
- `m_level`  out  2  buffer occupancy, 0..3.

## Operation
- State:
  - 3-entry circular buffer with 2-bit head and tail pointers, each wrapping 2→0.
  - `count` (0..3).
  - `inflight`: 1-bit register, set when a read was issued in the previous cycle.
- Issue: `p_read_en = read_rst_n & ~p_read_empty & (count + inflight < 3)`.
  - `p_read_en` depends only on registers, `p_read_empty` and reset.
  - It has no combinational path from `m_ready`.
- Capture: when `inflight` = 1, `p_read_data` is written at the tail, the tail advances and the push counts toward `count`.
- Pop: happens when `m_valid & m_ready`; the head advances.
- Next count: `count_next = count + push − pop`. Push and pop in the same cycle leave `count` unchanged.
- Overflow cannot occur: the issue rule reserves a slot for every in-flight word.
- `m_valid = (count != 0)`.
- `m_data` is the head entry. It is held stable while `m_valid & ~m_ready`.
- `m_level = count`.
- `m_ready` while `m_valid` = 0 has no effect.

## Timing
- Reset, sampled at a `read_clk` edge with `read_rst_n` = 0:
  - `count`, head, tail and `inflight` clear to 0.
  - Every storage entry clears to 0.
  - Outputs: `m_valid` = 0, `m_data` = 0, `m_level` = 0, `p_read_en` = 0.
- Reset mid-operation:
  - Buffered words and any in-flight word are discarded.
  - No word is presented until 2 cycles after the first non-empty cycle following reset release.
- Latency: `p_read_en` = 1 in cycle n gives `p_read_data` valid in n+1, captured at the end of n+1, with `m_valid` = 1 in n+2.
- Throughput: 1 word per cycle in steady state. `count` = 1 with `inflight` = 1 still issues.
- Back-pressure:
  - With `m_ready` = 0, reads continue until `count + inflight` = 3, then `p_read_en` drops.
  - At most 3 words are buffered.
- FIFO goes empty: `p_read_en` drops in the same cycle. The buffer drains normally.

## Configuration
- Macro: `FIFO_READ_STREAM_STATS_EN`.
- Defined:
  - Adds `stat_words` (out, 32) and `stat_stalls` (out, 32). Both reset to 0 and wrap at 2^32.
  - `stat_words` increments on every pop.
  - `stat_stalls` increments every cycle with `m_valid & ~m_ready`.
- Undefined: neither port nor either counter exists. Everything else is unchanged.

## Test plan
- Reset: hold `read_rst_n` = 0 for 4 cycles with `p_read_empty` = 0 → `p_read_en`, `m_valid`, `m_level`, `m_data` all 0.
- Streaming:
  - Stimulus: FIFO model preloaded with 0x00000000..0x0000000F, `m_ready` = 1.
  - Response: first `m_valid` 2 cycles after the first `p_read_en`; 16 consecutive valid cycles; data in order with no gaps.
- Back-pressure:
  - Stimulus: 8 words queued, `m_ready` = 0 for 10 cycles.
  - Response: exactly 3 reads issued; `m_level` = 3; `m_data` holds word 0 throughout.
  - Then: `m_ready` = 1 → words 0..7 delivered in order with none lost or duplicated.
- Simultaneous push/pop:
  - Stimulus: steady stream with `m_ready` toggling 1,0,1,0.
  - Response: `m_level` stays ≤ 3; the output sequence matches the input sequence exactly.
- Empty edge: a single word 0xDEADBEEF, then `p_read_empty` = 1 → exactly one read pulse; one valid beat of 0xDEADBEEF; afterwards `m_valid` = 0 and `p_read_en` = 0.
- Mid-stream reset:
  - Stimulus: assert reset with `m_level` = 2 and `inflight` = 1.
  - Response: next cycle `m_level` = 0 and `m_valid` = 0; the late `p_read_data` is not captured.
  - With the macro defined: `stat_words` and `stat_stalls` read 0.
